// File: rtl/trackball_pkg.sv
`default_nettype none
// ============================================================================
// trackball_pkg -- shared types and constants for the trackball step encoder
// Rev 1.0
// ============================================================================
package trackball_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } axis_state_e;

    typedef logic [8:0] step_cnt_t;

    localparam int PHASE_W = 16;
    typedef logic [PHASE_W-1:0] phase_cnt_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // 9 bits so that -128 maps to 128 steps
    function automatic step_cnt_t abs_steps(input logic [7:0] d);
        step_cnt_t ext;
        ext = {d[7], d};
        return d[7] ? step_cnt_t'(~ext + step_cnt_t'(1)) : ext;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trackball_axis_gen.sv
`default_nettype none
// ============================================================================
// trackball_axis_gen -- one axis: emits N clock pulses with setup/high/low timing
// Rev 1.0
// ============================================================================
module trackball_axis_gen
    import trackball_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int HIGH_CYC  = 4,
    parameter int LOW_CYC   = 4
) (
    input  logic      horclk,
    input  logic      rstclr_l,
    input  logic      start_i,
    input  step_cnt_t steps_i,
    input  logic      abort_i,
    output logic      clk_o,
    output logic      idle_o
);

    localparam phase_cnt_t SETUP_LAST = phase_cnt_t'(SETUP_CYC - 1);
    localparam phase_cnt_t HIGH_LAST  = phase_cnt_t'(HIGH_CYC - 1);
    localparam phase_cnt_t LOW_LAST   = phase_cnt_t'(LOW_CYC - 1);

    axis_state_e state_q;
    step_cnt_t   steps_q;
    phase_cnt_t  phase_q;
    logic        clk_q;

    always_ff @(posedge horclk or negedge rstclr_l) begin
        if (!rstclr_l) begin
            state_q <= IDLE;
            steps_q <= '0;
            phase_q <= '0;
            clk_q   <= 1'b0;
        end else if (abort_i && (state_q != IDLE)) begin
            state_q <= IDLE;
            steps_q <= '0;
            phase_q <= '0;
            clk_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && (steps_i != '0)) begin
                        state_q <= SETUP;
                        steps_q <= steps_i;
                        phase_q <= SETUP_LAST;
                    end
                end
                SETUP: begin
                    if (phase_q == '0) begin
                        state_q <= HIGH;
                        clk_q   <= 1'b1;
                        phase_q <= HIGH_LAST;
                    end else begin
                        phase_q <= phase_q - phase_cnt_t'(1);
                    end
                end
                HIGH: begin
                    // the step is consumed when its high phase completes
                    if (phase_q == '0) begin
                        state_q <= LOW;
                        clk_q   <= 1'b0;
                        steps_q <= steps_q - step_cnt_t'(1);
                        phase_q <= LOW_LAST;
                    end else begin
                        phase_q <= phase_q - phase_cnt_t'(1);
                    end
                end
                LOW: begin
                    if (phase_q == '0) begin
                        if (steps_q != '0) begin
                            state_q <= SETUP;
                            phase_q <= SETUP_LAST;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        phase_q <= phase_q - phase_cnt_t'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    clk_q   <= 1'b0;
                end
            endcase
        end
    end

    assign clk_o  = clk_q;
    assign idle_o = (state_q == IDLE);

endmodule
`default_nettype wire

// File: rtl/trackball_encoder.sv
`default_nettype none
// ============================================================================
// trackball_encoder -- turns (dx,dy) move requests into dir/clk step pulses
// Rev 1.0
// ============================================================================
module trackball_encoder
    import trackball_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int HIGH_CYC  = 4,
    parameter int LOW_CYC   = 4
) (
    input  logic       horclk,
    input  logic       rstclr_l,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_dx,
    input  logic [7:0] req_dy,
    input  logic       abort,
    output logic       hdir,
    output logic       hclk,
    output logic       vdir,
    output logic       vclk,
    output logic       done
);

    logic      busy_q;
    logic      done_q;
    logic      hdir_q;
    logic      vdir_q;
    logic      h_idle;
    logic      v_idle;
    logic      accept;
    step_cnt_t h_steps;
    step_cnt_t v_steps;

    assign h_steps   = abs_steps(req_dx);
    assign v_steps   = abs_steps(req_dy);
    // busy_q also covers the closing cycle where both axes are idle but done is pending
    assign req_ready = h_idle && v_idle && !busy_q && !done_q;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge horclk or negedge rstclr_l) begin
        if (!rstclr_l) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hdir_q <= DIR_UP;
            vdir_q <= DIR_UP;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                busy_q <= 1'b1;
                if (req_dx != 8'd0) begin
                    hdir_q <= req_dx[7] ? DIR_DOWN : DIR_UP;
                end
                if (req_dy != 8'd0) begin
                    vdir_q <= req_dy[7] ? DIR_DOWN : DIR_UP;
                end
            end else if (busy_q && (abort || (h_idle && v_idle))) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    trackball_axis_gen #(
        .SETUP_CYC (SETUP_CYC),
        .HIGH_CYC  (HIGH_CYC),
        .LOW_CYC   (LOW_CYC)
    ) u_axis_h (
        .horclk   (horclk),
        .rstclr_l (rstclr_l),
        .start_i  (accept),
        .steps_i  (h_steps),
        .abort_i  (abort),
        .clk_o    (hclk),
        .idle_o   (h_idle)
    );

    trackball_axis_gen #(
        .SETUP_CYC (SETUP_CYC),
        .HIGH_CYC  (HIGH_CYC),
        .LOW_CYC   (LOW_CYC)
    ) u_axis_v (
        .horclk   (horclk),
        .rstclr_l (rstclr_l),
        .start_i  (accept),
        .steps_i  (v_steps),
        .abort_i  (abort),
        .clk_o    (vclk),
        .idle_o   (v_idle)
    );

    assign hdir = hdir_q;
    assign vdir = vdir_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_trackball_encoder.sv
`default_nettype none
// ============================================================================
// tb_trackball_encoder -- randomized and directed moves against an edge-time model
// Rev 1.0
// ============================================================================
module tb_trackball_encoder;

    localparam int SETUP_CYC = 2;
    localparam int HIGH_CYC  = 4;
    localparam int LOW_CYC   = 4;
    localparam int PER       = SETUP_CYC + HIGH_CYC + LOW_CYC;

    logic       horclk    = 1'b0;
    logic       rstclr_l  = 1'b0;
    logic       req_valid = 1'b0;
    logic       abort     = 1'b0;
    logic [7:0] req_dx    = 8'd0;
    logic [7:0] req_dy    = 8'd0;
    logic       req_ready;
    logic       hdir, hclk, vdir, vclk, done;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   h_t[$];
    int   v_t[$];
    int   d_t[$];
    int   h_pos  = 0;
    int   v_pos  = 0;
    logic prev_h = 1'b0;
    logic prev_v = 1'b0;
    logic exp_hdir = 1'b0;
    logic exp_vdir = 1'b0;

    trackball_encoder #(
        .SETUP_CYC (SETUP_CYC),
        .HIGH_CYC  (HIGH_CYC),
        .LOW_CYC   (LOW_CYC)
    ) dut (
        .horclk    (horclk),
        .rstclr_l  (rstclr_l),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dx    (req_dx),
        .req_dy    (req_dy),
        .abort     (abort),
        .hdir      (hdir),
        .hclk      (hclk),
        .vdir      (vdir),
        .vclk      (vclk),
        .done      (done)
    );

    always #5 horclk = ~horclk;

    always @(posedge horclk) cyc <= cyc + 1;

    // quadrature-style decoder: position moves one count per rising clk edge
    always @(negedge horclk) begin
        if (hclk && !prev_h) begin
            h_t.push_back(cyc);
            h_pos += hdir ? -1 : 1;
        end
        if (vclk && !prev_v) begin
            v_t.push_back(cyc);
            v_pos += vdir ? -1 : 1;
        end
        if (done) d_t.push_back(cyc);
        prev_h = hclk;
        prev_v = vclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_edges(input int acc, input int n, input int dexp);
        int cnt = 0;
        for (int k = 0; k < n; k++)
            if (acc + SETUP_CYC + k * PER < dexp) cnt++;
        return cnt;
    endfunction

    function automatic int bad_edges(input int q[$], input int acc, input int n);
        int bad = 0;
        for (int k = 0; k < q.size(); k++)
            if (k >= n || q[k] != acc + SETUP_CYC + k * PER) bad++;
        return bad;
    endfunction

    task automatic send(input logic [7:0] bx, input logic [7:0] by, output int acc);
        int waited;
        @(posedge horclk); #2;
        req_valid = 1'b1;
        req_dx    = bx;
        req_dy    = by;
        waited    = 0;
        do begin
            @(negedge horclk); #1;
            waited++;
        end while (!req_ready && waited < 50);
        @(posedge horclk); #2;
        acc       = cyc;
        req_valid = 1'b0;
        req_dx    = 8'($urandom);
        req_dy    = 8'($urandom);
    endtask

    task automatic run_move(input int dx, input int dy, input int abort_at);
        int acc, nh, nv, nmax, dnat, dexp, eh, ev, waited, limit;
        h_t.delete(); v_t.delete(); d_t.delete();
        h_pos = 0;
        v_pos = 0;
        send(dx[7:0], dy[7:0], acc);
        nh   = (dx < 0) ? -dx : dx;
        nv   = (dy < 0) ? -dy : dy;
        nmax = (nh > nv) ? nh : nv;
        dnat = (nmax == 0) ? acc + 1
                           : acc + SETUP_CYC + (nmax - 1) * PER + HIGH_CYC + LOW_CYC + 1;
        dexp = dnat;
        if (abort_at >= 0 && acc + abort_at + 1 < dnat) dexp = acc + abort_at + 1;
        eh = exp_edges(acc, nh, dexp);
        ev = exp_edges(acc, nv, dexp);
        if (dx != 0) exp_hdir = (dx < 0);
        if (dy != 0) exp_vdir = (dy < 0);

        limit  = nmax * PER + 20;
        waited = 0;
        while (d_t.size() == 0 && waited < limit) begin
            @(negedge horclk); #1;
            waited++;
            abort = (abort_at >= 0 && cyc == acc + abort_at);
        end
        abort = 1'b0;
        check("clk_low_at_done", {hclk, vclk}, 0);
        check("ready_low_at_done", req_ready, 0);
        @(negedge horclk); #1;
        check("ready_after_done", req_ready, 1);
        repeat (3) @(negedge horclk);
        #1;
        check("h_edge_count", h_t.size(), eh);
        check("h_edge_timing", bad_edges(h_t, acc, eh), 0);
        check("h_position", h_pos, (dx < 0) ? -eh : eh);
        check("v_edge_count", v_t.size(), ev);
        check("v_edge_timing", bad_edges(v_t, acc, ev), 0);
        check("v_position", v_pos, (dy < 0) ? -ev : ev);
        check("done_count", d_t.size(), 1);
        check("done_time", (d_t.size() > 0) ? d_t[0] - acc : -1, dexp - acc);
        check("hdir", hdir, exp_hdir);
        check("vdir", vdir, exp_vdir);
    endtask

    initial begin
        int acc;
        #1;
        check("rst_outputs", {hclk, vclk, hdir, vdir, done}, 0);
        #21 rstclr_l = 1'b1;
        @(negedge horclk); #1;
        check("ready_after_reset", req_ready, 1);

        run_move(3, 0, -1);
        run_move(-5, 2, -1);
        run_move(-128, 0, -1);
        check("decoder_mod16", h_pos & 15, 0);
        run_move(10, 0, 15);
        run_move(0, 0, -1);

        // abort while idle must be ignored
        d_t.delete();
        @(negedge horclk); abort = 1'b1;
        @(negedge horclk); abort = 1'b0;
        repeat (5) @(negedge horclk);
        #1;
        check("idle_abort_no_done", d_t.size(), 0);
        check("idle_abort_ready", req_ready, 1);

        // reset mid-move while hclk is high with hdir=1
        d_t.delete();
        send(8'hF6, 8'h03, acc);
        while (cyc < acc + 13) @(negedge horclk);
        #1;
        check("pre_reset_hclk", {hclk, hdir}, 2'b11);
        rstclr_l = 1'b0;
        #1;
        check("async_reset_out", {hclk, vclk, hdir, vdir, done}, 0);
        exp_hdir = 1'b0;
        exp_vdir = 1'b0;
        repeat (2) @(posedge horclk);
        #2 rstclr_l = 1'b1;
        repeat (20) @(negedge horclk);
        #1;
        check("reset_no_done", d_t.size(), 0);
        run_move(7, -3, -1);

        for (int i = 0; i < 10; i++) begin
            int rdx, rdy, rab;
            rdx = int'($urandom_range(0, 255)) - 128;
            rdy = int'($urandom_range(0, 255)) - 128;
            if (i < 4) begin
                rdx = rdx / 8;
                rdy = rdy / 8;
            end
            rab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 80)) : -1;
            run_move(rdx, rdy, rab);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
